// File: rtl/calc_seq_ctrl.sv
// Button front end and display scanner for the 4-bit signed accumulator calculator.
// Debounced presses become single fixed-width push/clear strobes; digits are time-multiplexed.
module calc_seq_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 2,
    parameter int SCAN_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       clr_raw,
    input  logic [3:0] sw_in,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic [3:0] acc_in,
    output logic       acc_push,
    output logic       acc_reset,
    output logic [3:0] an,
    output logic [3:0] seg_code,
    output logic       busy
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CLR} state_t;

    // index 0 = push button, index 1 = clear button
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [3:0]      sw1_q, sw2_q;
    logic [1:0]      deb_q, deb_d, deb_prev_q;
    logic [1:0][7:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      flush_q, flush_d;
    logic            armed_q, armed_d;
    logic            push_edge, clr_edge;

    state_t          state_q, state_d;
    logic [3:0]      pcnt_q, pcnt_d;
    logic            pend_q, pend_d;
    logic [3:0]      acc_in_q, acc_in_d;
    logic            acc_push_q, acc_push_d;
    logic            acc_rst_q, acc_rst_d;
    logic            busy_q, busy_d;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        slot_q, slot_d;
    logic [3:0]        an_q, an_d;
    logic [3:0]        seg_q, seg_d;
    logic              scan_wrap;
    logic [3:0]        slot_code;

    assign raw = {clr_raw, btn_raw};

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = 8'd0;
            end else if (deb_cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
                deb_d[i]     = ~deb_q[i];
                deb_cnt_d[i] = 8'd0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end
        end
    end

    // A button already held when reset releases must be let go before it can push again;
    // wait for the synchroniser to flush before trusting its low level.
    always_comb begin
        flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
        armed_d = armed_q | ((flush_q == 2'd2) & ~sync2_q[0]);
    end

    assign push_edge = deb_q[0] & ~deb_prev_q[0] & armed_q;
    assign clr_edge  = deb_q[1] & ~deb_prev_q[1];

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        pend_d   = pend_q;
        acc_in_d = acc_in_q;
        case (state_q)
            IDLE: begin
                if (clr_edge || pend_q) begin
                    state_d  = CLR;
                    pcnt_d   = 4'd0;
                    acc_in_d = 4'd0;
                end else if (push_edge) begin
                    state_d  = SETUP;
                    acc_in_d = sw2_q;
                end
            end
            SETUP: begin
                if (clr_edge) pend_d = 1'b1;
                state_d = PULSE;
                pcnt_d  = 4'd0;
            end
            PULSE: begin
                if (clr_edge) pend_d = 1'b1;
                if (pcnt_q == 4'(PULSE_LEN - 1)) begin
                    state_d = HOLD;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (clr_edge) pend_d = 1'b1;
                if (!deb_q[0]) state_d = IDLE;
            end
            CLR: begin
                pend_d = 1'b0;
                if (pcnt_q == 4'(PULSE_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // strobes come straight from flops so the edge-triggered accumulator never sees a glitch
        acc_push_d = (state_d == PULSE);
        acc_rst_d  = (state_d == CLR);
        busy_d     = (state_d != IDLE);
    end

    assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        case (slot_q)
            2'd0:    slot_code = d1;
            2'd1:    slot_code = d2;
            2'd2:    slot_code = d3;
            default: slot_code = d4;
        endcase
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        slot_d     = slot_q;
        an_d       = an_q;
        seg_d      = seg_q;
        if (scan_wrap) begin
            scan_cnt_d = '0;
            slot_d     = slot_q + 2'd1;
            an_d       = ~(4'b0001 << slot_q);
            seg_d      = slot_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sw1_q      <= '0;
            sw2_q      <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            deb_cnt_q  <= '0;
            flush_q    <= '0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            pcnt_q     <= '0;
            pend_q     <= 1'b0;
            acc_in_q   <= '0;
            acc_push_q <= 1'b0;
            acc_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            scan_cnt_q <= '0;
            slot_q     <= '0;
            an_q       <= 4'b1111;
            seg_q      <= 4'hF;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            sw1_q      <= sw_in;
            sw2_q      <= sw1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            flush_q    <= flush_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_q     <= pend_d;
            acc_in_q   <= acc_in_d;
            acc_push_q <= acc_push_d;
            acc_rst_q  <= acc_rst_d;
            busy_q     <= busy_d;
            scan_cnt_q <= scan_cnt_d;
            slot_q     <= slot_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign acc_in    = acc_in_q;
    assign acc_push  = acc_push_q;
    assign acc_reset = reset | acc_rst_q;
    assign an        = an_q;
    assign seg_code  = seg_q;
    assign busy      = busy_q;

endmodule
